alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 150 +++++++++++++++
 tb/tb_alu_issue.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Decodes MIPS-style ALU instructions into ALU operands/control behind a main+skid issue buffer.
// Latency: 1 cycle from input transfer to out_valid when the buffer is empty or draining.
// Backpressure: in_ready is registered and drops only when both main and skid hold entries.
module alu_issue #(
  parameter int B = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  logic [15:0]  imm16,
  input  logic [B-1:0] rs_data,
  input  logic [B-1:0] rt_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [B-1:0] op1,
  output logic [B-1:0] op2,
  output logic [3:0]   alu_control,
  output logic         illegal,
  output logic [15:0]  issue_count
);

  typedef struct packed {
    logic [B-1:0] op1;
    logic [B-1:0] op2;
    logic [3:0]   ctl;
    logic         ill;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam entry_t RESET_ENTRY = '{op1: '0, op2: '0, ctl: 4'hF, ill: 1'b0};
  localparam entry_t ILLEGAL_ENTRY = '{op1: '0, op2: '0, ctl: 4'hF, ill: 1'b1};

  state_t       state;
  entry_t       main_q;
  entry_t       skid_q;
  entry_t       dec;
  logic         legal;
  logic [3:0]   ctl;
  logic [B-1:0] opb;
  logic [B-1:0] imm_sext;
  logic [B-1:0] imm_zext;
  logic         in_xfer;
  logic         out_xfer;

  assign imm_sext = {{(B-16){imm16[15]}}, imm16};
  assign imm_zext = {{(B-16){1'b0}}, imm16};
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Decode the presented instruction into an ALU entry; unknown encodings become a poisoned entry.
  always_comb begin
    legal = 1'b1;
    ctl   = 4'hF;
    opb   = rt_data;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000: ctl = 4'b0010;
          6'b100010: ctl = 4'b0110;
          6'b100100: ctl = 4'b0000;
          6'b100101: ctl = 4'b0001;
          6'b101010: ctl = 4'b0111;
          default:   legal = 1'b0;
        endcase
      end
      6'b001000: begin ctl = 4'b0010; opb = imm_sext; end
      6'b001010: begin ctl = 4'b0111; opb = imm_sext; end
      6'b001100: begin ctl = 4'b0000; opb = imm_zext; end
      6'b001101: begin ctl = 4'b0001; opb = imm_zext; end
      6'b100011: begin ctl = 4'b0010; opb = imm_sext; end
      6'b101011: begin ctl = 4'b0010; opb = imm_sext; end
      6'b000100: ctl = 4'b0110;
      default:   legal = 1'b0;
    endcase
    if (legal) begin
      dec = '{op1: rs_data, op2: opb, ctl: ctl, ill: 1'b0};
    end else begin
      dec = ILLEGAL_ENTRY;
    end
  end

  // Main/skid buffer state machine with registered handshake outputs; flush overrides everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      main_q    <= RESET_ENTRY;
      skid_q    <= RESET_ENTRY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q    <= dec;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= dec;
          end else if (in_xfer) begin
            skid_q   <= dec;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (out_xfer) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Count completed output transfers; survives flush, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_count <= 16'h0000;
    end else if (out_xfer && !flush) begin
      issue_count <= issue_count + 16'h0001;
    end
  end

  assign op1         = main_q.op1;
  assign op2         = main_q.op2;
  assign alu_control = main_q.ctl;
  assign illegal     = main_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a queue-based reference model and per-cycle compare.
// Latency: model entries become visible the cycle after acceptance.
// Backpressure: model accepts only while it holds fewer than two entries.
module tb_alu_issue;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctl;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  alu_control;
  logic        illegal;
  logic [15:0] issue_count;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  exp_t        q[$];
  logic [15:0] mcnt;

  alu_issue #(.B(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .imm16(imm16),
    .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .alu_control(alu_control),
    .illegal(illegal), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction semantics as a table: what an ALU would be told for each encoding.
  function automatic exp_t model_dec(input logic [5:0] opc, input logic [5:0] fn,
                                     input logic [15:0] imm, input logic [31:0] rs,
                                     input logic [31:0] rt);
    logic [31:0] se;
    logic [31:0] ze;
    exp_t e;
    se = {{16{imm[15]}}, imm};
    ze = {16'h0000, imm};
    e  = '{op1: 32'h0, op2: 32'h0, ctl: 4'hF, ill: 1'b1};
    if (opc == 6'h00) begin
      case (fn)
        6'h20: e = '{op1: rs, op2: rt, ctl: 4'd2, ill: 1'b0};
        6'h22: e = '{op1: rs, op2: rt, ctl: 4'd6, ill: 1'b0};
        6'h24: e = '{op1: rs, op2: rt, ctl: 4'd0, ill: 1'b0};
        6'h25: e = '{op1: rs, op2: rt, ctl: 4'd1, ill: 1'b0};
        6'h2A: e = '{op1: rs, op2: rt, ctl: 4'd7, ill: 1'b0};
        default: ;
      endcase
    end else begin
      case (opc)
        6'h08: e = '{op1: rs, op2: se, ctl: 4'd2, ill: 1'b0};
        6'h0A: e = '{op1: rs, op2: se, ctl: 4'd7, ill: 1'b0};
        6'h0C: e = '{op1: rs, op2: ze, ctl: 4'd0, ill: 1'b0};
        6'h0D: e = '{op1: rs, op2: ze, ctl: 4'd1, ill: 1'b0};
        6'h23: e = '{op1: rs, op2: se, ctl: 4'd2, ill: 1'b0};
        6'h2B: e = '{op1: rs, op2: se, ctl: 4'd2, ill: 1'b0};
        6'h04: e = '{op1: rs, op2: rt, ctl: 4'd6, ill: 1'b0};
        default: ;
      endcase
    end
    return e;
  endfunction

  // Reference model: a two-deep FIFO plus a transfer counter.
  always @(posedge clk or negedge reset_n) begin
    bit ox;
    bit ix;
    if (!reset_n) begin
      q.delete();
      mcnt = 16'h0000;
    end else if (flush) begin
      q.delete();
    end else begin
      ox = (q.size() > 0) && out_ready;
      ix = in_valid && (q.size() < 2);
      if (ox) begin
        void'(q.pop_front());
        mcnt = mcnt + 16'h0001;
      end
      if (ix) q.push_back(model_dec(opcode, funct, imm16, rs_data, rt_data));
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", out_valid, q.size() > 0);
      chk("m_in_ready", in_ready, q.size() < 2);
      chk("m_issue_count", issue_count, mcnt);
      if (q.size() > 0) begin
        chk("m_op1", op1, q[0].op1);
        chk("m_op2", op2, q[0].op2);
        chk("m_alu_control", alu_control, q[0].ctl);
        chk("m_illegal", illegal, q[0].ill);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [5:0] opc, input logic [5:0] fn, input logic [15:0] imm,
                     input logic [31:0] rs, input logic [31:0] rt);
    in_valid = 1'b1;
    opcode   = opc;
    funct    = fn;
    imm16    = imm;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  initial begin
    int g;
    logic [15:0] saved;
    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct = '0; imm16 = '0; rs_data = '0; rt_data = '0;
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_op1", op1, 32'h0);
    chk("rst_op2", op2, 32'h0);
    chk("rst_alu_control", alu_control, 4'hF);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_issue_count", issue_count, 16'h0);
    #2 reset_n = 1'b1;
    cycle();

    // add 5,3
    out_ready = 1'b1;
    put(6'h00, 6'h20, 16'h0, 32'd5, 32'd3);
    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("add_out_valid", out_valid, 1'b1);
    chk("add_op1", op1, 32'd5);
    chk("add_op2", op2, 32'd3);
    chk("add_ctl", alu_control, 4'b0010);
    cycle();
    @(negedge clk);
    chk("add_issue_count", issue_count, 16'd1);

    // addi / ori with imm16 = FFFF
    put(6'h08, 6'h00, 16'hFFFF, 32'h0, 32'h0);
    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("addi_op2", op2, 32'hFFFF_FFFF);
    chk("addi_ctl", alu_control, 4'b0010);
    put(6'h0D, 6'h00, 16'hFFFF, 32'h0, 32'h0);
    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ori_op2", op2, 32'h0000_FFFF);
    chk("ori_ctl", alu_control, 4'b0001);
    cycle();

    // Stream of mixed legal ops, checked by the model each cycle
    put(6'h00, 6'h22, 16'h0, 32'h10, 32'h4);      cycle();
    put(6'h00, 6'h24, 16'h0, 32'hF0F0, 32'hFF00); cycle();
    put(6'h00, 6'h25, 16'h0, 32'h1, 32'h2);       cycle();
    put(6'h00, 6'h2A, 16'h0, 32'h3, 32'h9);       cycle();
    put(6'h0A, 6'h00, 16'h8000, 32'h7, 32'h0);    cycle();
    put(6'h0C, 6'h00, 16'h8001, 32'hFFFF, 32'h0); cycle();
    put(6'h23, 6'h00, 16'hFFFC, 32'h100, 32'h0);  cycle();
    put(6'h2B, 6'h00, 16'h0004, 32'h200, 32'h0);  cycle();
    put(6'h04, 6'h15, 16'h1234, 32'hA, 32'hB);    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("beq_ctl", alu_control, 4'b0110);
    chk("beq_op2", op2, 32'hB);
    cycle();

    // Backpressure: three inputs with out_ready low
    out_ready = 1'b0;
    put(6'h00, 6'h20, 16'h0, 32'd1, 32'd0); cycle();
    put(6'h00, 6'h20, 16'h0, 32'd2, 32'd0); cycle();
    put(6'h00, 6'h20, 16'h0, 32'd3, 32'd0);
    @(negedge clk);
    chk("bp_in_ready_full", in_ready, 1'b0);
    chk("bp_first_op1", op1, 32'd1);
    cycle();
    cycle();
    @(negedge clk);
    chk("bp_hold_op1", op1, 32'd1);
    out_ready = 1'b1;
    cycle();
    @(negedge clk);
    chk("bp_second_op1", op1, 32'd2);
    chk("bp_in_ready_reopen", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_third_op1", op1, 32'd3);
    cycle();
    @(negedge clk);
    chk("bp_drained", out_valid, 1'b0);

    // Flush while FULL with a valid input presented
    out_ready = 1'b0;
    put(6'h00, 6'h20, 16'h0, 32'd11, 32'd0); cycle();
    put(6'h00, 6'h20, 16'h0, 32'd12, 32'd0); cycle();
    saved = issue_count;
    flush = 1'b1;
    put(6'h00, 6'h20, 16'h0, 32'd13, 32'd0);
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_issue_count", issue_count, saved);

    // Illegal encodings
    out_ready = 1'b1;
    put(6'h3F, 6'h00, 16'h5555, 32'd7, 32'd9);
    cycle();
    put(6'h00, 6'h07, 16'h0, 32'd7, 32'd9);
    @(negedge clk);
    chk("ill1_ctl", alu_control, 4'hF);
    chk("ill1_op1", op1, 32'h0);
    chk("ill1_op2", op2, 32'h0);
    chk("ill1_illegal", illegal, 1'b1);
    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ill2_ctl", alu_control, 4'hF);
    chk("ill2_op1", op1, 32'h0);
    chk("ill2_op2", op2, 32'h0);
    chk("ill2_illegal", illegal, 1'b1);
    cycle();

    // Counter wrap
    put(6'h00, 6'h20, 16'h0, 32'd1, 32'd1);
    g = 0;
    while (issue_count != 16'hFFFF && g < 70000) begin
      cycle();
      g++;
    end
    chk("preload_count", issue_count, 16'hFFFF);
    in_valid = 1'b0;
    cycle();
    @(negedge clk);
    chk("wrap_count", issue_count, 16'h0000);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    put(6'h00, 6'h20, 16'h0, 32'd21, 32'd22); cycle();
    put(6'h00, 6'h22, 16'h0, 32'd23, 32'd24); cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_arst_in_ready", in_ready, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_op1", op1, 32'h0);
    chk("arst_op2", op2, 32'h0);
    chk("arst_alu_control", alu_control, 4'hF);
    chk("arst_illegal", illegal, 1'b0);
    chk("arst_issue_count", issue_count, 16'h0);
    #3 reset_n = 1'b1;
    cycle();
    cycle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
